rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin arbiter sharing one resource among N=8 requesters.
// Rotating priority pointer plus a per-owner hold limit (MAX_HOLD) for fairness.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   arbiter enable; low drops/blocks any grant
//   req[N-1:0]   in   request vector, bit i = requester i wants/keeps resource
//   grant[N-1:0] out  registered one-hot grant (zero when no owner)
//   grant_idx    out  binary index of owner; holds last value when idle
//   grant_valid  out  OR of grant
//   switch_pulse out  one-cycle pulse alongside each new grant
module rr_grant_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 switch_pulse
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      hold_q, hold_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            pulse_q, pulse_d;

  // Candidates exclude the current owner: on release its bit is already low,
  // on preemption the owner must not win again. In IDLE grant_q is zero, so
  // the same search serves the initial arbitration.
  logic [N-1:0]    cand;
  logic            found;
  logic [IW-1:0]   win;
  logic [IW-1:0]   c;

  always_comb begin
    cand  = req & ~grant_q;
    found = 1'b0;
    win   = ptr_q;
    c     = ptr_q;
    // Walk from the farthest offset down so the closest-to-ptr hit wins.
    for (int i = N - 1; i >= 0; i--) begin
      c = ptr_q + IW'(i);
      if (cand[c]) begin
        found = 1'b1;
        win   = c;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = BUSY;
          grant_d = N'(1) << win;
          idx_d   = win;
          ptr_d   = win + IW'(1);
          hold_d  = 8'd1;
          pulse_d = 1'b1;
        end
      end
      BUSY: begin
        if (!en || (!req[idx_q] && !found)) begin
          // Disabled, or owner released with nobody waiting.
          state_d = IDLE;
          grant_d = '0;
          hold_d  = 8'd0;
        end else if (!req[idx_q] || (hold_q == 8'(MAX_HOLD) && found)) begin
          // Release hand-off or hold-limit preemption, same edge.
          grant_d = N'(1) << win;
          idx_d   = win;
          ptr_d   = win + IW'(1);
          hold_d  = 8'd1;
          pulse_d = 1'b1;
        end else if (hold_q == 8'(MAX_HOLD)) begin
          // Sole requester: restart its hold window silently.
          hold_d  = 8'd1;
        end else if (hold_q != 8'hFF) begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
    end
  end

  assign grant        = grant_q;
  assign grant_idx    = idx_q;
  assign grant_valid  = |grant_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter (MAX_HOLD=4). The driver pushes the
// hand-computed expected outputs for each applied vector; the monitor pops and
// compares one entry after each rising edge (or right after an async reset).
module tb_rr_grant_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       switch_pulse;

  rr_grant_arbiter #(.N(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(grant), .grant_idx(grant_idx),
    .grant_valid(grant_valid), .switch_pulse(switch_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       p;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errs    = 0;
  event chk_ev;

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        vectors++;
        if (grant !== e.g || grant_idx !== e.idx || grant_valid !== e.v ||
            switch_pulse !== e.p) begin
          errs++;
          $display("FAIL vec%0d @%0t: got grant=%h idx=%0d valid=%b pulse=%b, want grant=%h idx=%0d valid=%b pulse=%b",
                   vectors, $time, grant, grant_idx, grant_valid, switch_pulse,
                   e.g, e.idx, e.v, e.p);
        end
      end
    end
  end

  function automatic exp_t own(input int o, input logic p);
    exp_t e;
    e.g   = 8'h01 << o;
    e.idx = 3'(o);
    e.v   = 1'b1;
    e.p   = p;
    return e;
  endfunction

  function automatic exp_t none(input int last_idx);
    exp_t e;
    e.g   = 8'h00;
    e.idx = 3'(last_idx);
    e.v   = 1'b0;
    e.p   = 1'b0;
    return e;
  endfunction

  // Apply inputs between edges; the expectation is for after the next edge.
  task automatic step(input logic en_i, input logic [7:0] req_i, input exp_t e);
    @(negedge clk);
    en  = en_i;
    req = req_i;
    sbq.push_back(e);
  endtask

  // Reset asserted mid-cycle: outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 8'h00;
    sbq.push_back(none(0));
    -> chk_ev;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset / idle
    do_reset();
    repeat (5) step(1'b1, 8'h00, none(0));

    // Single request, then drop
    step(1'b1, 8'h08, own(3, 1'b1));
    step(1'b1, 8'h08, own(3, 1'b0));
    step(1'b1, 8'h00, none(3));
    step(1'b1, 8'h00, none(3));

    // Round-robin wrap: each owner drops its bit the cycle after its grant
    do_reset();
    step(1'b1, 8'hFF, own(0, 1'b1));
    for (int i = 1; i <= 9; i++)
      step(1'b1, 8'hFF & ~(8'h01 << ((i - 1) % 8)), own(i % 8, 1'b1));
    step(1'b1, 8'h00, none(1));

    // Hold-limit preemption (MAX_HOLD=4), then a sole requester
    do_reset();
    step(1'b1, 8'h24, own(2, 1'b1));
    repeat (3) step(1'b1, 8'h24, own(2, 1'b0));
    step(1'b1, 8'h24, own(5, 1'b1));
    repeat (3) step(1'b1, 8'h24, own(5, 1'b0));
    step(1'b1, 8'h24, own(2, 1'b1));
    repeat (10) step(1'b1, 8'h04, own(2, 1'b0));

    // Enable drop, then ptr=7 wraps so 0 beats 6
    do_reset();
    step(1'b1, 8'h40, own(6, 1'b1));
    step(1'b0, 8'h40, none(6));
    step(1'b0, 8'h40, none(6));
    step(1'b1, 8'h41, own(0, 1'b1));

    // Async reset mid-grant, regrant afterwards
    do_reset();
    step(1'b1, 8'h10, own(4, 1'b1));
    step(1'b1, 8'h10, own(4, 1'b0));
    do_reset();
    step(1'b1, 8'h10, own(4, 1'b1));
    // ptr was 5 before this reset; 4 winning over 5 shows it restarted at 0
    do_reset();
    step(1'b1, 8'h30, own(4, 1'b1));
    step(1'b1, 8'h00, none(4));

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
